// File: rtl/instr_mem_loader_if.sv
// Byte-receive / instruction-memory write bus of instr_mem_loader.
// master = loader side (drives the write port), slave = UART receiver / memory side.
interface instr_mem_loader_if #(
  parameter int INST_SZ = 32,
  parameter int BYTE_SZ = 8,
  parameter int ADDR_SZ = 8
);
  logic               i_start;
  logic [BYTE_SZ-1:0] i_rx_data;
  logic               i_rx_valid;
  logic               o_wr_en;
  logic [ADDR_SZ-1:0] o_wr_addr;
  logic [INST_SZ-1:0] o_wr_data;

  modport master (
    input  i_start, i_rx_data, i_rx_valid,
    output o_wr_en, o_wr_addr, o_wr_data
  );

  modport slave (
    output i_start, i_rx_data, i_rx_valid,
    input  o_wr_en, o_wr_addr, o_wr_data
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs received bytes MSB-first into instruction words and writes them to consecutive
// addresses until HALT or memory full. Define LOADER_CHECKSUM_EN for a trailing XOR checksum word.
module instr_mem_loader #(
  parameter int                 INST_SZ    = 32,
  parameter int                 BYTE_SZ    = 8,
  parameter int                 ADDR_SZ    = 8,
  parameter logic [INST_SZ-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  instr_mem_loader_if.master  bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overflow,
  output logic [ADDR_SZ:0]    o_word_count,
  output logic                o_chk_err
);

  localparam int BPW   = INST_SZ / BYTE_SZ;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WC_W  = ADDR_SZ + 1;
  localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(BPW - 1);
  localparam logic [ADDR_SZ-1:0] ADDR_MAX  = '1;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_CHECK = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [INST_SZ-1:0] word_q, word_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_SZ-1:0] addr_q, addr_d;
  logic               ovf_q, ovf_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_SZ-1:0] wr_addr_q, wr_addr_d;
  logic [INST_SZ-1:0] wr_data_q, wr_data_d;
  logic [WC_W-1:0]    word_count_q, word_count_d;
  logic               busy_q, done_q, overflow_q;
  logic               keep_s;
  logic [INST_SZ-1:0] shift_word_s;

`ifdef LOADER_CHECKSUM_EN
  logic [INST_SZ-1:0] xor_q, xor_d;
  logic               chk_flag_q, chk_flag_d;
  logic               chk_err_q;
`endif

  assign shift_word_s = {word_q[INST_SZ-BYTE_SZ-1:0], bus.i_rx_data};

  // Next-state, datapath and write-port decode.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    ovf_d        = ovf_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    word_count_d = word_count_q;
    keep_s       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    xor_d        = xor_q;
    chk_flag_d   = chk_flag_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.i_start) begin
          state_d      = S_RECV;
          word_d       = '0;
          cnt_d        = '0;
          addr_d       = '0;
          ovf_d        = 1'b0;
          word_count_d = '0;
`ifdef LOADER_CHECKSUM_EN
          xor_d        = '0;
          chk_flag_d   = 1'b0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_RECV: begin
        if (bus.i_rx_valid) begin
          word_d = shift_word_s;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BYTE) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RECV;
          end
        end else begin
          state_d = S_RECV;
        end
      end
      S_WRITE: begin
        wr_en_d      = 1'b1;
        wr_addr_d    = addr_q;
        wr_data_d    = word_q;
        word_count_d = word_count_q + WC_W'(1);
`ifdef LOADER_CHECKSUM_EN
        xor_d        = xor_q ^ word_q;
`endif
        if (word_q == HALT_INSTR) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
          keep_s  = 1'b1;
`else
          state_d = S_DONE;
`endif
        end else if (addr_q == ADDR_MAX) begin
          state_d = S_DONE;
          ovf_d   = 1'b1;
        end else begin
          state_d = S_RECV;
          addr_d  = addr_q + ADDR_SZ'(1);
          keep_s  = 1'b1;
        end
        // A byte landing in the write cycle is byte 0 of the next word (counter is 0 here).
        if (bus.i_rx_valid && keep_s) begin
          word_d = shift_word_s;
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          cnt_d  = cnt_q;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (bus.i_rx_valid) begin
          word_d = shift_word_s;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BYTE) begin
            state_d    = S_DONE;
            chk_flag_d = (shift_word_s != xor_q);
          end else begin
            state_d = S_CHECK;
          end
        end else begin
          state_d = S_CHECK;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and datapath registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      ovf_q        <= 1'b0;
      word_count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= '0;
      chk_flag_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      ovf_q        <= ovf_d;
      word_count_q <= word_count_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
      chk_flag_q   <= chk_flag_d;
`endif
    end
  end

  // Registered outputs; status flags follow the state one cycle later so done trails the last strobe.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_err_q  <= 1'b0;
`endif
    end else begin
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef LOADER_CHECKSUM_EN
      busy_q     <= (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHECK);
      chk_err_q  <= (state_q == S_DONE) && chk_flag_q;
`else
      busy_q     <= (state_q == S_RECV) || (state_q == S_WRITE);
`endif
      done_q     <= (state_q == S_DONE);
      overflow_q <= (state_q == S_DONE) && ovf_q;
    end
  end

  assign bus.o_wr_en   = wr_en_q;
  assign bus.o_wr_addr = wr_addr_q;
  assign bus.o_wr_data = wr_data_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_overflow    = overflow_q;
  assign o_word_count  = word_count_q;
`ifdef LOADER_CHECKSUM_EN
  assign o_chk_err     = chk_err_q;
`else
  assign o_chk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a default instance plus an ADDR_SZ=2 instance for overflow.
module tb_instr_mem_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;

  always #5 clk = ~clk;

  instr_mem_loader_if #(.INST_SZ(32), .BYTE_SZ(8), .ADDR_SZ(8)) bus_a ();
  instr_mem_loader_if #(.INST_SZ(32), .BYTE_SZ(8), .ADDR_SZ(2)) bus_b ();

  assign bus_a.i_start    = start;
  assign bus_a.i_rx_data  = rx_data;
  assign bus_a.i_rx_valid = rx_valid;
  assign bus_b.i_start    = start;
  assign bus_b.i_rx_data  = rx_data;
  assign bus_b.i_rx_valid = rx_valid;

  logic       busy_a, done_a, ovf_a, chk_a;
  logic [8:0] cnt_a;
  logic       busy_b, done_b, ovf_b, chk_b;
  logic [2:0] cnt_b;

  instr_mem_loader #(.INST_SZ(32), .BYTE_SZ(8), .ADDR_SZ(8), .HALT_INSTR(HALT)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus_a),
    .o_busy(busy_a), .o_done(done_a), .o_overflow(ovf_a),
    .o_word_count(cnt_a), .o_chk_err(chk_a)
  );

  instr_mem_loader #(.INST_SZ(32), .BYTE_SZ(8), .ADDR_SZ(2), .HALT_INSTR(HALT)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus_b),
    .o_busy(busy_b), .o_done(done_b), .o_overflow(ovf_b),
    .o_word_count(cnt_b), .o_chk_err(chk_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wd_a[$];
  int          wa_a[$];
  int          wc_a[$];
  logic [31:0] wd_b[$];
  int          wa_b[$];

  always @(negedge clk) begin
    if (bus_a.o_wr_en === 1'b1) begin
      wd_a.push_back(bus_a.o_wr_data);
      wa_a.push_back(int'(bus_a.o_wr_addr));
      wc_a.push_back(cyc);
    end
    if (bus_b.o_wr_en === 1'b1) begin
      wd_b.push_back(bus_b.o_wr_data);
      wa_b.push_back(int'(bus_b.o_wr_addr));
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // All tasks start and end right after a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], (i == 3) ? 0 : gap);
    end
  endtask

  task automatic send_cksum(input logic [31:0] x);
`ifdef LOADER_CHECKSUM_EN
    send_word(x, 0);
`else
    rx_data = x[7:0];
    @(negedge clk);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_logs();
    wd_a.delete(); wa_a.delete(); wc_a.delete();
    wd_b.delete(); wa_b.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_status", {busy_a, done_a, ovf_a, chk_a, cnt_a, bus_a.o_wr_en}, 64'd0);
    check("reset_bus", {bus_a.o_wr_addr, bus_a.o_wr_data}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a word.
    pulse_start();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    check("busy_in_recv", busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", {busy_a, done_a, ovf_a, cnt_a, bus_a.o_wr_en, bus_a.o_wr_addr, bus_a.o_wr_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_strobe_after_reset", wd_a.size(), 0);
    pulse_start();
    send_word(32'hA1B2C3D4, 0);
    @(negedge clk);
    check("post_reset_wr", {bus_a.o_wr_en, bus_a.o_wr_addr, bus_a.o_wr_data}, {23'd0, 1'b1, 8'h00, 32'hA1B2C3D4});
    send_word(HALT, 0);
    send_cksum(32'h5E4D3C2B);
    repeat (3) @(negedge clk);
    check("post_reset_done", done_a, 1'b1);

    // Three-word program with spaced bytes.
    clear_logs();
    pulse_start();
    send_word(32'h8C220000, 1);
    send_word(32'h00221821, 1);
    send_word(HALT, 1);
    check("pre_strobe_done", done_a, 1'b0);
    @(negedge clk);
    check("halt_strobe", {bus_a.o_wr_en, bus_a.o_wr_addr, bus_a.o_wr_data}, {23'd0, 1'b1, 8'h02, HALT});
`ifndef LOADER_CHECKSUM_EN
    @(negedge clk);
    check("done_after_strobe", {bus_a.o_wr_en, done_a, busy_a, ovf_a}, 64'b0100);
`endif
    send_cksum(32'h73FFE7DE);
    repeat (3) @(negedge clk);
    check("prog3_count", cnt_a, 9'd3);
    check("prog3_flags", {done_a, ovf_a, busy_a, chk_a}, 64'b1000);
    check("prog3_nwr", wd_a.size(), 3);
    check("prog3_w0", {wa_a[0][7:0], wd_a[0]}, {8'h00, 32'h8C220000});
    check("prog3_w1", {wa_a[1][7:0], wd_a[1]}, {8'h01, 32'h00221821});
    check("prog3_w2", {wa_a[2][7:0], wd_a[2]}, {8'h02, HALT});

    // Back-to-back bytes: byte 0 of word 1 lands in the write cycle of word 0.
    clear_logs();
    pulse_start();
    send_word(32'h11223344, 0);
    send_word(HALT, 0);
    send_cksum(32'hEEDDCCBB);
    repeat (3) @(negedge clk);
    check("b2b_nwr", wd_a.size(), 2);
    check("b2b_w0", {wa_a[0][7:0], wd_a[0]}, {8'h00, 32'h11223344});
    check("b2b_w1", {wa_a[1][7:0], wd_a[1]}, {8'h01, HALT});
    check("b2b_spacing", wc_a[1] - wc_a[0], 4);
    check("b2b_count", cnt_a, 9'd2);

    // Start inside RECV is ignored; bytes in DONE are ignored; new start clears status.
    clear_logs();
    pulse_start();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    pulse_start();
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    repeat (2) @(negedge clk);
    check("ign_start_nwr", wd_a.size(), 1);
    check("ign_start_w0", {wa_a[0][7:0], wd_a[0]}, {8'h00, 32'hAABBCCDD});
    send_word(HALT, 0);
    send_cksum(32'h55443322);
    repeat (3) @(negedge clk);
    check("ign_done", {done_a, cnt_a}, {54'd0, 1'b1, 9'd2});
    send_word(32'h01020304, 0);
    repeat (3) @(negedge clk);
    check("ign_rx_in_done", {wd_a.size() == 2, done_a, cnt_a}, {53'd0, 1'b1, 1'b1, 9'd2});
    pulse_start();
    @(negedge clk);
    check("restart_clear", {done_a, busy_a, cnt_a}, {53'd0, 1'b0, 1'b1, 9'd0});
    send_word(32'h55667788, 0);
    @(negedge clk);
    check("restart_wr", {bus_a.o_wr_en, bus_a.o_wr_addr, bus_a.o_wr_data}, {23'd0, 1'b1, 8'h00, 32'h55667788});
    send_word(HALT, 0);
    send_cksum(32'hAA998877);
    repeat (3) @(negedge clk);

`ifdef LOADER_CHECKSUM_EN
    // Checksum good, then bad.
    clear_logs();
    pulse_start();
    send_word(32'h00000001, 0);
    send_word(HALT, 0);
    send_word(32'hFFFFFFFE, 0);
    repeat (3) @(negedge clk);
    check("cksum_ok", {done_a, chk_a, cnt_a}, {53'd0, 1'b1, 1'b0, 9'd2});
    check("cksum_nwr", wd_a.size(), 2);
    pulse_start();
    send_word(32'h00000001, 0);
    send_word(HALT, 0);
    send_word(32'h00000000, 0);
    repeat (3) @(negedge clk);
    check("cksum_bad", {done_a, chk_a}, 64'b11);
`else
    check("chk_err_tied", chk_a, 1'b0);
`endif

    // Overflow on the ADDR_SZ=2 instance.
    clear_logs();
    pulse_start();
    send_word(32'h00000010, 0);
    send_word(32'h00000020, 0);
    send_word(32'h00000030, 0);
    send_word(32'h00000040, 0);
    repeat (3) @(negedge clk);
    check("ovf_nwr", wd_b.size(), 4);
    check("ovf_w0", {wa_b[0][1:0], wd_b[0]}, {2'd0, 32'h00000010});
    check("ovf_w3", {wa_b[3][1:0], wd_b[3]}, {2'd3, 32'h00000040});
    check("ovf_flags", {done_b, ovf_b, busy_b, chk_b, cnt_b}, {57'd0, 4'b1100, 3'd4});
    check("no_ovf_big_mem", {ovf_a, busy_a, cnt_a}, {53'd0, 1'b0, 1'b1, 9'd4});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
